// File: rtl/mp_top_param.sv
// mp_top_param
// A tiny accumulator machine with its own program/data memory.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-high reset
//   start      : begin execution at address 0 (only from IDLE or HALT)
//   ld_we      : program-load write strobe (only from IDLE or HALT)
//   ld_addr    : program-load address
//   ld_data    : program-load data
//   in_data    : input word for the IN instruction
//   in_valid   : input word is valid
//   in_ready   : machine is waiting to take in_data
//   out_data   : word produced by the OUT instruction
//   out_valid  : out_data is valid until out_ack is seen
//   out_ack    : consumer has taken out_data
//   acc_out    : accumulator
//   pc         : program counter
//   mem_out    : registered memory read data
//   mem_write  : high during the cycle a STORE writes memory
//   halted     : machine is in HALT
//   busy       : machine is executing (not IDLE, not HALT)
//
// Instruction word: opcode in the top 3 bits, operand address below.

module mp_top_param #(
    parameter  int ADDR_W = 5,
    localparam int DATA_W = ADDR_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] mem_out,
    output logic              mem_write,
    output logic              halted,
    output logic              busy
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_OUT   = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_IN,
        S_WAIT_OUT,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_memOut;
    logic [DATA_W-1:0] r_outData;
    logic              r_outValid;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic [2:0]        w_irOp;
    logic [ADDR_W-1:0] w_irArg;
    logic              w_idleLike;
    logic              w_store;
    logic              w_inReady;
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memWAddr;
    logic [DATA_W-1:0] w_memWData;

    assign w_irOp     = r_ir[DATA_W-1:ADDR_W];
    assign w_irArg    = r_ir[ADDR_W-1:0];
    assign w_idleLike = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_store    = (r_state == S_EXEC) && (w_irOp == OP_STORE);
    assign w_inReady  = ((r_state == S_EXEC) || (r_state == S_WAIT_IN)) && (w_irOp == OP_IN);

    // In DECODE the instruction is only just arriving on mem_out, so the
    // operand fetch must use mem_out directly rather than the IR.
    assign w_rdAddr   = (r_state == S_DECODE) ? r_memOut[ADDR_W-1:0] : r_pc;

    // STORE only happens while busy and loads only while idle, so the two
    // writers never collide.
    assign w_memWe    = w_store || (w_idleLike && ld_we);
    assign w_memWAddr = w_store ? w_irArg : ld_addr;
    assign w_memWData = w_store ? r_acc   : ld_data;

    // Memory array has no reset so programs survive a reset.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memWAddr] <= w_memWData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memOut <= '0;
        end else begin
            r_memOut <= r_mem[w_rdAddr];
        end
    end

    // Main control: FETCH -> DECODE -> EXEC, with IN/OUT able to stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_acc      <= '0;
            r_ir       <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_acc   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= r_memOut;
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (w_irOp)
                        OP_LOAD:  r_acc <= r_memOut;
                        OP_STORE: ;
                        OP_ADD:   r_acc <= r_acc + r_memOut;
                        OP_SUB:   r_acc <= r_acc - r_memOut;
                        OP_JZ: begin
                            if (r_acc == '0) begin
                                r_pc <= w_irArg;
                            end
                        end
                        OP_OUT: begin
                            r_outData  <= r_acc;
                            r_outValid <= 1'b1;
                            r_state    <= S_WAIT_OUT;
                        end
                        OP_IN: begin
                            if (in_valid) begin
                                r_acc <= in_data;
                            end else begin
                                r_state <= S_WAIT_IN;
                            end
                        end
                        OP_HALT:  r_state <= S_HALT;
                        default:  r_state <= S_FETCH;
                    endcase
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        r_acc   <= in_data;
                        r_state <= S_FETCH;
                    end
                end
                S_WAIT_OUT: begin
                    if (out_ack) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_inReady;
    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign acc_out   = r_acc;
    assign pc        = r_pc;
    assign mem_out   = r_memOut;
    assign mem_write = w_store;
    assign halted    = (r_state == S_HALT);
    assign busy      = !w_idleLike;

endmodule

// File: tb/tb_mp_top_param.sv
// tb_mp_top_param
// Self-checking bench for mp_top_param (ADDR_W=5, DATA_W=8). Expected OUT
// words go into a queue when a program is launched or an input is supplied,
// and are popped when the machine presents them on out_data.

module tb_mp_top_param;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ld_we;
    logic [4:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ack;
    logic [7:0] acc_out;
    logic [4:0] pc;
    logic [7:0] mem_out;
    logic       mem_write;
    logic       halted;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int memWrites = 0;
    int inXfers = 0;
    logic [4:0] prevPc = '0;
    logic sawWrap = 1'b0;
    logic [7:0] expQ[$];

    mp_top_param #(.ADDR_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ld_we(ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ack(out_ack),
        .acc_out(acc_out),
        .pc(pc),
        .mem_out(mem_out),
        .mem_write(mem_write),
        .halted(halted),
        .busy(busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count store strobes, input transfers and the 31 -> 0 pc wrap.
    always @(posedge clk) begin
        if (mem_write) memWrites++;
        if (in_valid && in_ready) inXfers++;
        if (prevPc == 5'd31 && pc == 5'd0 && busy) sawWrap = 1'b1;
        prevPc = pc;
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [4:0] addr, input logic [7:0] data);
        ld_we   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk); #1;
        ld_we   = 1'b0;
    endtask

    // Pulse start for one edge; the machine is in FETCH afterwards.
    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitHalt(input int startCnt, output int cycles);
        cycles = startCnt;
        while (!halted && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!halted) checkOutput("haltTimeout", 32'd0, 32'd1);
    endtask

    // Wait for an OUT word, hold off ack for ackDelay cycles checking that
    // the word stays put, then ack and check that out_valid drops.
    task automatic waitOut(input int ackDelay);
        int n;
        logic [7:0] exp;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checkOutput("outTimeout", 32'd0, 32'd1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput("sbUnderflow", 32'd0, 32'd1);
            exp = 8'h00;
        end else begin
            exp = expQ.pop_front();
        end
        checkOutput("outData", out_data, exp);
        for (int i = 0; i < ackDelay; i++) begin
            @(posedge clk); #1;
            checkOutput("outValidHold", out_valid, 1);
            checkOutput("outDataHold", out_data, exp);
        end
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        checkOutput("outDrop", out_valid, 0);
    endtask

    initial begin
        int cyc;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        ld_we    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        in_data  = '0;
        in_valid = 1'b0;
        out_ack  = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstPc", pc, 0);
        checkOutput("rstAcc", acc_out, 0);
        checkOutput("rstMemOut", mem_out, 0);
        checkOutput("rstOutData", out_data, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstMemWrite", mem_write, 0);
        checkOutput("rstHalted", halted, 0);
        checkOutput("rstBusy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // LOAD 20, ADD 21, STORE 22, HALT; start and a load are attempted
        // while busy and must both be ignored.
        loadWord(5'd0, 8'h14);
        loadWord(5'd1, 8'h55);
        loadWord(5'd2, 8'h36);
        loadWord(5'd3, 8'hE0);
        loadWord(5'd20, 8'd7);
        loadWord(5'd21, 8'd5);
        memWrites = 0;
        start = 1'b1;
        @(posedge clk); #1;
        checkOutput("busyRun", busy, 1);
        ld_we   = 1'b1;
        ld_addr = 5'd21;
        ld_data = 8'h99;
        @(posedge clk); #1;
        start = 1'b0;
        ld_we = 1'b0;
        waitHalt(1, cyc);
        checkOutput("haltCycles", cyc, 12);
        checkOutput("sumAcc", acc_out, 8'd12);
        checkOutput("sumPc", pc, 4);
        checkOutput("storePulses", memWrites, 1);
        checkOutput("haltBusy", busy, 0);

        // Read back M22 and M21 through OUT.
        loadWord(5'd0, 8'h16);
        loadWord(5'd1, 8'hA0);
        loadWord(5'd2, 8'h15);
        loadWord(5'd3, 8'hA0);
        loadWord(5'd4, 8'hE0);
        expQ.push_back(8'd12);
        expQ.push_back(8'd5);
        applyStimulus();
        waitOut(0);
        waitOut(0);
        waitHalt(0, cyc);

        // Subtraction wraps modulo 256.
        loadWord(5'd0, 8'h14);
        loadWord(5'd1, 8'h75);
        loadWord(5'd2, 8'hA0);
        loadWord(5'd3, 8'hE0);
        loadWord(5'd20, 8'd3);
        expQ.push_back(8'hFE);
        applyStimulus();
        waitOut(0);
        waitHalt(0, cyc);
        checkOutput("subAcc", acc_out, 8'hFE);

        // IN with in_valid held low for four cycles.
        loadWord(5'd0, 8'h80);
        loadWord(5'd1, 8'hA0);
        loadWord(5'd2, 8'hE0);
        applyStimulus();
        checkOutput("inReadyEarly", in_ready, 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        inXfers = 0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("inReadyWait", in_ready, 1);
            @(posedge clk); #1;
        end
        in_data  = 8'h5A;
        in_valid = 1'b1;
        expQ.push_back(8'h5A);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("inAcc", acc_out, 8'h5A);
        checkOutput("inReadyDone", in_ready, 0);
        waitOut(0);
        waitHalt(0, cyc);
        checkOutput("inXfers", inXfers, 1);

        // OUT with the ack held off for three cycles.
        loadWord(5'd0, 8'h17);
        loadWord(5'd1, 8'hA0);
        loadWord(5'd2, 8'hE0);
        loadWord(5'd23, 8'h33);
        expQ.push_back(8'h33);
        applyStimulus();
        waitOut(3);
        waitHalt(0, cyc);
        checkOutput("outPc", pc, 3);

        // JZ taken to 31, pc wraps, then JZ not taken.
        loadWord(5'd0, 8'hDF);
        loadWord(5'd1, 8'hA0);
        loadWord(5'd2, 8'hE0);
        loadWord(5'd31, 8'h18);
        loadWord(5'd24, 8'h42);
        sawWrap = 1'b0;
        expQ.push_back(8'h42);
        applyStimulus();
        waitOut(0);
        waitHalt(0, cyc);
        checkOutput("pcWrap", sawWrap, 1);
        checkOutput("jzPc", pc, 3);
        checkOutput("jzAcc", acc_out, 8'h42);

        // Reset while waiting on an OUT ack, then rerun the same program.
        loadWord(5'd0, 8'h17);
        loadWord(5'd1, 8'hA0);
        loadWord(5'd2, 8'hE0);
        applyStimulus();
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("preRstValid", out_valid, 1);
        checkOutput("preRstData", out_data, 8'h33);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstData", out_data, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstPc", pc, 0);
        checkOutput("midRstAcc", acc_out, 0);
        checkOutput("midRstMemOut", mem_out, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expQ.push_back(8'h33);
        applyStimulus();
        waitOut(1);
        waitHalt(0, cyc);
        checkOutput("rerunAcc", acc_out, 8'h33);
        checkOutput("rerunPc", pc, 3);
        checkOutput("sbEmpty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
